// File: rtl/alu_pipe.sv
// Request/response ALU: single-cycle ops finish in one edge, MUL is an iterative shift-add.
// Define ALU_PIPE_MUL_EN to build the multiplier; without it sel 7 returns 0 in one cycle.
module alu_pipe #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] op1,
  input  logic [DATA_W-1:0] op2,
  input  logic [2:0]        sel,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] result,
  output logic              zero,
  output logic              carry,
  output logic [1:0]        dbg_state
);

  // Handshake: a request transfers on an edge with in_valid && in_ready; a result
  // transfers on an edge with out_valid && out_ready. in_ready is high only in IDLE,
  // out_valid only in DONE, so one transaction is in flight at a time.
  typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, DONE = 2'd2} state_t;

  localparam logic [DATA_W:0] W_LIM = (DATA_W + 1)'(DATA_W);

  state_t            state, state_nxt;
  logic              load;
  logic [DATA_W:0]   sum, diff;
  logic              shift_oob;
  logic [DATA_W-1:0] alu_res;
  logic              alu_carry;

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign dbg_state = state;

  assign sum       = {1'b0, op1} + {1'b0, op2};
  assign diff      = {1'b0, op1} - {1'b0, op2};
  assign shift_oob = ({1'b0, op2} >= W_LIM);

  always_comb begin
    alu_res   = '0;
    alu_carry = 1'b0;
    case (sel)
      3'd0: alu_res = op2;
      3'd1: begin alu_res = sum[DATA_W-1:0];  alu_carry = sum[DATA_W];  end
      3'd2: alu_res = op1 & op2;
      3'd3: alu_res = op1 | op2;
      3'd4: begin alu_res = diff[DATA_W-1:0]; alu_carry = diff[DATA_W]; end
      3'd5: alu_res = shift_oob ? '0 : (op1 << op2);
      3'd6: alu_res = shift_oob ? '0 : (op1 >> op2);
      default: alu_res = '0;
    endcase
  end

`ifdef ALU_PIPE_MUL_EN
  localparam int CW = $clog2(DATA_W);

  logic [2*DATA_W-1:0] mcand, acc, acc_nxt;
  logic [DATA_W-1:0]   mplier;
  logic [CW-1:0]       cnt;
  logic                mul_start, mul_last;

  assign acc_nxt  = mplier[0] ? (acc + mcand) : acc;
  assign mul_last = (cnt == CW'(DATA_W - 1));

  // One multiplier bit per BUSY edge; the DATA_W-th BUSY edge writes the result.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mcand  <= '0;
      mplier <= '0;
      acc    <= '0;
      cnt    <= '0;
    end else if (mul_start) begin
      mcand  <= {{DATA_W{1'b0}}, op1};
      mplier <= op2;
      acc    <= '0;
      cnt    <= '0;
    end else if (state == BUSY) begin
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      acc    <= acc_nxt;
      cnt    <= cnt + 1'b1;
    end
  end
`endif

  always_comb begin
    state_nxt = state;
    load      = 1'b0;
`ifdef ALU_PIPE_MUL_EN
    mul_start = 1'b0;
`endif
    case (state)
      IDLE: begin
        if (in_valid) begin
`ifdef ALU_PIPE_MUL_EN
          if (sel == 3'd7) begin
            state_nxt = BUSY;
            mul_start = 1'b1;
          end else begin
            state_nxt = DONE;
            load      = 1'b1;
          end
`else
          state_nxt = DONE;
          load      = 1'b1;
`endif
        end
      end
      BUSY: begin
`ifdef ALU_PIPE_MUL_EN
        if (mul_last) state_nxt = DONE;
`else
        state_nxt = IDLE;
`endif
      end
      DONE:    if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      result <= '0;
      zero   <= 1'b0;
      carry  <= 1'b0;
    end else if (load) begin
      result <= alu_res;
      zero   <= (alu_res == '0);
      carry  <= alu_carry;
    end
`ifdef ALU_PIPE_MUL_EN
    else if ((state == BUSY) && mul_last) begin
      result <= acc_nxt[DATA_W-1:0];
      zero   <= (acc_nxt[DATA_W-1:0] == '0);
      carry  <= |acc_nxt[2*DATA_W-1:DATA_W];
    end
`endif
  end

endmodule

// File: tb/tb_alu_pipe.sv
// Bench for alu_pipe (DATA_W=8): directed vector table, hand-written corner sequences
// and random requests checked against an arithmetic reference model.
module tb_alu_pipe;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         reset_n;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] op1, op2;
  logic [2:0]   sel;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] result;
  logic         zero, carry;
  logic [1:0]   dbg_state;

  int n_cmp  = 0;
  int n_fail = 0;

  logic [W+1:0] exp_q[$];

`ifdef ALU_PIPE_MUL_EN
  localparam int MUL_LAT = W;
`else
  localparam int MUL_LAT = 1;
`endif

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [2:0]   s;
    logic [W-1:0] r;
    logic         z;
    logic         c;
  } vec_t;

  alu_pipe #(.DATA_W(W)) dut (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
    .op1(op1), .op2(op2), .sel(sel), .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .zero(zero), .carry(carry), .dbg_state(dbg_state)
  );

  // clock and watchdog
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Reference model: returns {carry, zero, result}
  function automatic logic [W+1:0] ref_alu(input logic [W-1:0] a, input logic [W-1:0] b,
                                           input logic [2:0] s);
    int unsigned ia, ib, t, r;
    logic c;
    ia = a; ib = b; c = 1'b0; r = 0;
    case (s)
      3'd0: r = ib;
      3'd1: begin t = ia + ib; r = t % 256; c = (t > 255); end
      3'd2: r = ia & ib;
      3'd3: r = ia | ib;
      3'd4: begin r = (ia + 256 - ib) % 256; c = (ia < ib); end
      3'd5: r = (ib >= W) ? 0 : (ia * (1 << ib)) % 256;
      3'd6: r = (ib >= W) ? 0 : ia / (1 << ib);
      default: begin
`ifdef ALU_PIPE_MUL_EN
        t = ia * ib; r = t % 256; c = (t > 255);
`else
        r = 0;
`endif
      end
    endcase
    return {c, (r == 0), r[W-1:0]};
  endfunction

  // Driver: issue one request, follow it to DONE, hold it, then release it.
  // Called #1 after a rising edge with the DUT in IDLE.
  task automatic run_req(input logic [W-1:0] a, input logic [W-1:0] b, input logic [2:0] s,
                         input logic [W+1:0] expv, input int hold);
    int lat;
    logic rdy_seen;
    logic [W+1:0] got_exp;
    check("accept_in_ready", in_ready, 1);
    in_valid = 1'b1; op1 = a; op2 = b; sel = s; out_ready = 1'b0;
    exp_q.push_back(expv);
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 1;
    rdy_seen = 1'b0;
    while (!out_valid && lat < 40) begin
      if (in_ready) rdy_seen = 1'b1;
      in_valid = 1'(($urandom_range(0, 1)));
      op1 = W'($urandom); op2 = W'($urandom); sel = 3'($urandom);
      @(posedge clk); #1;
      lat++;
    end
    in_valid = 1'b0;
    check("busy_in_ready_low", rdy_seen, 0);
    check("latency", lat, (s == 3'd7) ? MUL_LAT : 1);
    got_exp = exp_q.pop_front();
    check("result", result, got_exp[W-1:0]);
    check("zero", zero, got_exp[W]);
    check("carry", carry, got_exp[W+1]);
    for (int i = 0; i < hold; i++) begin
      in_valid = 1'b1; op1 = W'($urandom); op2 = W'($urandom); sel = 3'($urandom);
      @(posedge clk); #1;
      check("hold_state", {out_valid, in_ready, carry, zero, result}, {2'b10, got_exp});
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("release_idle", {out_valid, in_ready}, 2'b01);
  endtask

  vec_t tbl[$];

  initial begin
    logic [W-1:0] a, b;
    logic [2:0]   s;
    int           seen;

    // reset phase: requests offered during reset must not be captured
    reset_n = 1'b0; in_valid = 1'b1; op1 = 8'd5; op2 = 8'd7; sel = 3'd1; out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_outputs", {out_valid, in_ready, carry, zero, result}, {2'b01, 2'b00, 8'd0});
    reset_n = 1'b1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    check("post_reset_no_capture", {out_valid, in_ready}, 2'b01);

    // directed table
    tbl.push_back('{8'd5,   8'd7,  3'd1, 8'd12,  1'b0, 1'b0});
    tbl.push_back('{8'd5,   8'd7,  3'd0, 8'd7,   1'b0, 1'b0});
    tbl.push_back('{8'd5,   8'd12, 3'd2, 8'd4,   1'b0, 1'b0});
    tbl.push_back('{8'd10,  8'd12, 3'd3, 8'd14,  1'b0, 1'b0});
    tbl.push_back('{8'd200, 8'd100,3'd1, 8'd44,  1'b0, 1'b1});
    tbl.push_back('{8'd7,   8'd7,  3'd4, 8'd0,   1'b1, 1'b0});
    tbl.push_back('{8'd5,   8'd7,  3'd4, 8'd254, 1'b0, 1'b1});
    tbl.push_back('{8'd3,   8'd2,  3'd5, 8'd12,  1'b0, 1'b0});
    tbl.push_back('{8'd3,   8'd9,  3'd5, 8'd0,   1'b1, 1'b0});
    tbl.push_back('{8'd128, 8'd7,  3'd6, 8'd1,   1'b0, 1'b0});
    tbl.push_back('{8'd128, 8'd8,  3'd6, 8'd0,   1'b1, 1'b0});
`ifdef ALU_PIPE_MUL_EN
    tbl.push_back('{8'd12,  8'd13, 3'd7, 8'd156, 1'b0, 1'b0});
    tbl.push_back('{8'd20,  8'd20, 3'd7, 8'd144, 1'b0, 1'b1});
`else
    tbl.push_back('{8'd12,  8'd13, 3'd7, 8'd0,   1'b1, 1'b0});
    tbl.push_back('{8'd20,  8'd20, 3'd7, 8'd0,   1'b1, 1'b0});
`endif
    foreach (tbl[i])
      run_req(tbl[i].a, tbl[i].b, tbl[i].s, {tbl[i].c, tbl[i].z, tbl[i].r}, 0);

    // DONE held for 3 cycles with in_valid pulses
    run_req(8'd5, 8'd7, 3'd1, {1'b0, 1'b0, 8'd12}, 3);

    // reset asserted mid-request (cycle 4 of MUL, or pending DONE without MUL)
    in_valid = 1'b1; op1 = 8'd12; op2 = 8'd13; sel = 3'd7;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #3;
    reset_n = 1'b0;
    #1;
    check("abort_reset_outputs", {out_valid, in_ready, carry, zero, result}, {2'b01, 2'b00, 8'd0});
    @(posedge clk); #1;
    reset_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 12; i++) begin
      if (out_valid) seen++;
      @(posedge clk); #1;
    end
    check("abort_no_out_valid", seen, 0);
    run_req(8'd9, 8'd6, 3'd4, ref_alu(8'd9, 8'd6, 3'd4), 0);

    // random requests against the reference model
    for (int i = 0; i < 60; i++) begin
      s = 3'($urandom_range(0, 7));
      a = W'($urandom_range(0, 255));
      b = (s == 3'd5 || s == 3'd6) ? W'($urandom_range(0, 10)) : W'($urandom_range(0, 255));
      run_req(a, b, s, ref_alu(a, b, s), $urandom_range(0, 2));
    end

    check("scoreboard_empty", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_pipe.md
ALU_PIPE -- requirements
Module: alu_pipe

Interface
REQ-001 SHALL have parameter DATA_W, default 8, operand/result width (legal range 4..32).
REQ-002 SHALL have port clk  input  1  single clock, all state updates on rising edge.
REQ-003 SHALL have port reset_n  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port in_valid  input  1  request valid.
REQ-005 SHALL have port in_ready  output  1  block accepts request; high exactly when state is IDLE.
REQ-006 SHALL have ports op1, op2  input  DATA_W  operands.
REQ-007 SHALL have port sel  input  3  operation select.
REQ-008 SHALL have port out_valid  output  1  result valid.
REQ-009 SHALL have port out_ready  input  1  consumer takes result.
REQ-010 SHALL have port result  output  DATA_W  registered result.
REQ-011 SHALL have ports zero, carry  output  1 each  registered flags.

Function
REQ-012 SHALL accept a request on a rising edge where in_valid and in_ready are both high, capturing op1, op2 and sel.
REQ-013 SHALL use states IDLE, BUSY, DONE: IDLE->DONE on accept of sel 0..6; IDLE->BUSY on accept of sel 7; BUSY->DONE after the final multiply iteration; DONE->IDLE on an edge where out_ready is high.
REQ-014 SHALL implement sel: 0 FWD result=op2; 1 ADD op1+op2; 2 AND; 3 OR; 4 SUB op1-op2; 5 SHL op1<<op2; 6 SHR op1>>op2 (logical); 7 MUL.
REQ-015 SHALL produce 0 from SHL/SHR when op2 >= DATA_W.
REQ-016 SHALL truncate all results to DATA_W bits; carry = carry-out for ADD, borrow (op1<op2) for SUB, 1 if upper DATA_W product bits nonzero for MUL, 0 otherwise.
REQ-017 SHALL set zero = 1 exactly when the registered result equals 0.
REQ-018 SHALL assert out_valid on the first edge after acceptance for sel 0..6 (latency 1).
REQ-019 SHALL compute MUL by iterative shift-add, one operand bit per cycle, asserting out_valid exactly DATA_W edges after the accepting edge.
REQ-020 SHALL hold result, zero, carry and out_valid stable in DONE until out_ready is sampled high, then drop out_valid on that edge.
REQ-021 SHALL keep in_ready low in BUSY and DONE; in_valid in those states is ignored and SHALL not alter any state.
REQ-022 SHALL give at most one accepted request per two cycles (no bypass from DONE to accept).

Reset
REQ-023 SHALL, while reset_n is low, force state IDLE, result 0, zero 0, carry 0, out_valid 0, and clear all multiplier registers, independent of clk.
REQ-024 SHALL not capture a request on any edge while reset_n is low; the first capture is possible on the first rising edge with reset_n high.
REQ-025 SHALL abort an in-progress MUL or a pending DONE result on reset assertion; no out_valid for the aborted request follows.

Configuration
REQ-026 SHALL compile the multiplier only when macro ALU_PIPE_MUL_EN is defined.
REQ-027 SHALL, without ALU_PIPE_MUL_EN, treat sel 7 as a single-cycle op: IDLE->DONE, result 0, zero 1, carry 0, BUSY never entered.

Verification (DATA_W=8)
REQ-028 SHALL cover: op1=5, op2=7, sel=1 -> result 12, zero 0, carry 0, out_valid one edge after accept; then sel=0 -> 7; sel=2 op2=12 -> 4; sel=3 op1=10 op2=12 -> 14.
REQ-029 SHALL cover: ADD 200+100 -> 44, carry 1; SUB 7-7 -> 0, zero 1, carry 0; SUB 5-7 -> 254, carry 1.
REQ-030 SHALL cover: SHL op1=3 op2=2 -> 12; SHL op1=3 op2=9 -> 0, zero 1; SHR op1=128 op2=7 -> 1.
REQ-031 SHALL cover (ALU_PIPE_MUL_EN defined): MUL 12*13 -> 156, carry 0, out_valid exactly 8 edges after accept, in_ready low throughout; 20*20 -> 144, carry 1; without macro MUL -> 0, zero 1, latency 1.
REQ-032 SHALL cover: out_ready held low 3 cycles in DONE -> result/flags stable, in_ready low, in_valid pulses ignored; out_ready high -> IDLE next edge.
REQ-033 SHALL cover: reset_n pulsed low mid-MUL (cycle 4) -> outputs 0 immediately, out_valid never asserted for that request, next request after release completes normally.
